// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard unit for a 5-stage in-order pipeline with a variable-latency data
//   memory. It provides:
//     * operand forwarding selects for the E stage (M beats W),
//     * a load-use stall in D,
//     * a redirect flush (PCSrc) of D and E,
//     * a whole-pipe freeze while the data memory has not acknowledged,
//       with a timeout that drops the unit into a sticky error state,
//     * saturating stall / flush performance counters.
//
// Ports
//   clk, rst               clock (rising edge), async active-low reset
//   RS1D, RS2D             decode-stage source registers
//   RS1E, RS2E, RDE        execute-stage sources / destination
//   RDM, RDW               memory / writeback destinations
//   RegWriteM, RegWriteW   register-write enables in M and W
//   ResultSrcE             E-stage result select (2'b01 = load)
//   PCSrc                  redirect resolved in E
//   MemReqM                load/store present in M
//   dmem_ack               data memory completes the access this cycle
//   ForwardAE, ForwardBE   00 = RD, 01 = ResultW, 10 = ALUResultM
//   StallF/D/E/M           hold PC, IF/ID, ID/EX, EX/MEM
//   FlushD/E/W             bubble into IF/ID, ID/EX, MEM/WB
//   dmem_req               request to data memory
//   mem_err                sticky access-timeout flag
//   stall_cnt, flush_cnt   saturating performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int TIMEOUT = 15,  // 1..255 WAIT cycles before an access fails
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      RS1D,
  input  logic [4:0]      RS2D,
  input  logic [4:0]      RS1E,
  input  logic [4:0]      RS2E,
  input  logic [4:0]      RDE,
  input  logic [4:0]      RDM,
  input  logic [4:0]      RDW,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic [1:0]      ResultSrcE,
  input  logic            PCSrc,
  input  logic            MemReqM,
  input  logic            dmem_ack,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            StallM,
  output logic            FlushD,
  output logic            FlushE,
  output logic            FlushW,
  output logic            dmem_req,
  output logic            mem_err,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  localparam int WCW = 8;  // wide enough for TIMEOUT-1 up to 254
  localparam logic [WCW-1:0] LAST_WAIT = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [WCW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic           r_mem_err;
  logic [CNTW-1:0] r_stall_cnt, r_flush_cnt;

  logic w_lw_stall;
  logic w_mem_stall;
  logic w_in_err;

  // ---------------------------------------------------------------------------
  // Forwarding: the youngest producer (M) takes priority over W. x0 is never
  // forwarded since it always reads as zero.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (RegWriteM && (RDM != 5'd0) && (RDM == rs))
      sel = 2'b10;
    else if (RegWriteW && (RDW != 5'd0) && (RDW == rs))
      sel = 2'b01;
    return sel;
  endfunction

  assign ForwardAE = fwd_sel(RS1E);
  assign ForwardBE = fwd_sel(RS2E);

  // ---------------------------------------------------------------------------
  // Load-use: a load in E whose destination is read by the instruction in D.
  // ---------------------------------------------------------------------------
  assign w_lw_stall = (ResultSrcE == 2'b01) && (RDE != 5'd0) &&
                      ((RDE == RS1D) || (RDE == RS2D));

  // ---------------------------------------------------------------------------
  // Memory-wait freeze. A zero-wait access (ack with the request) costs
  // nothing; once in ERR the pipe is frozen until reset.
  // ---------------------------------------------------------------------------
  assign w_in_err    = (r_state == S_ERR);
  assign w_mem_stall = (MemReqM && !dmem_ack && !w_in_err) || w_in_err;
  assign dmem_req    = MemReqM && !w_in_err;

  // While frozen, load-use and redirect are held off: the instructions that
  // raise them are themselves held in place, so they re-present once the
  // freeze lifts and act then.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (w_mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      // M is held, so W must take a bubble rather than retire M twice.
      FlushW = 1'b1;
    end else begin
      StallF = w_lw_stall;
      StallD = w_lw_stall;
      FlushE = w_lw_stall || PCSrc;
      FlushD = PCSrc;
    end
  end

  // ---------------------------------------------------------------------------
  // Access FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      S_IDLE: begin
        if (MemReqM && !dmem_ack) begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = '0;
        end
      end
      S_WAIT: begin
        if (dmem_ack)
          w_state_nxt = S_IDLE;
        else if (r_wait_cnt == LAST_WAIT)
          w_state_nxt = S_ERR;
        else
          w_wait_cnt_nxt = r_wait_cnt + 8'd1;
      end
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      // Registered alongside the state so it tracks state==ERR exactly.
      r_mem_err  <= (w_state_nxt == S_ERR);
    end
  end

  assign mem_err = r_mem_err;

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallF && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (FlushD && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk, rst;
  logic [4:0] RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW;
  logic       RegWriteM, RegWriteW, PCSrc, MemReqM, dmem_ack;
  logic [1:0] ResultSrcE;

  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic        dmem_req, mem_err;
  logic [15:0] stall_cnt, flush_cnt;

  // second instance with narrow counters for the saturation corner
  logic [1:0] d2_fa, d2_fb;
  logic       d2_sf, d2_sd, d2_se, d2_sm, d2_fd, d2_fe, d2_fw, d2_req, d2_err;
  logic [2:0] d2_scnt, d2_fcnt;

  int n_chk = 0;
  int n_fail = 0;

  hazard_ctrl #(.TIMEOUT(15), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .RS1D(RS1D), .RS2D(RS2D), .RS1E(RS1E), .RS2E(RS2E),
    .RDE(RDE), .RDM(RDM), .RDW(RDW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrc(PCSrc), .MemReqM(MemReqM), .dmem_ack(dmem_ack),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE),
    .FlushW(FlushW), .dmem_req(dmem_req), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.TIMEOUT(15), .CNTW(3)) dut2 (
    .clk(clk), .rst(rst), .RS1D(RS1D), .RS2D(RS2D), .RS1E(RS1E), .RS2E(RS2E),
    .RDE(RDE), .RDM(RDM), .RDW(RDW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrc(PCSrc), .MemReqM(MemReqM), .dmem_ack(dmem_ack),
    .ForwardAE(d2_fa), .ForwardBE(d2_fb), .StallF(d2_sf), .StallD(d2_sd),
    .StallE(d2_se), .StallM(d2_sm), .FlushD(d2_fd), .FlushE(d2_fe),
    .FlushW(d2_fw), .dmem_req(d2_req), .mem_err(d2_err),
    .stall_cnt(d2_scnt), .flush_cnt(d2_fcnt)
  );

  // {FA, FB, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, dmem_req}
  logic [11:0] outs;
  assign outs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                 FlushD, FlushE, FlushW, dmem_req};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic        rwm, rww;
    logic [1:0]  rsrc;
    logic        pcs, mreq, ack;
    logic [11:0] exp;
  } vec_t;

  vec_t tv[12];

  function automatic vec_t mk(input string nm,
      input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
      input logic rwm, rww, input logic [1:0] rsrc,
      input logic pcs, mreq, ack, input logic [11:0] exp);
    vec_t v;
    v.name = nm; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.rwm = rwm; v.rww = rww;
    v.rsrc = rsrc; v.pcs = pcs; v.mreq = mreq; v.ack = ack; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    RS1D = v.rs1d; RS2D = v.rs2d; RS1E = v.rs1e; RS2E = v.rs2e; RDE = v.rde;
    RDM = v.rdm; RDW = v.rdw; RegWriteM = v.rwm; RegWriteW = v.rww;
    ResultSrcE = v.rsrc; PCSrc = v.pcs; MemReqM = v.mreq; dmem_ack = v.ack;
  endtask

  task automatic clear_in();
    RS1D = 0; RS2D = 0; RS1E = 0; RS2E = 0; RDE = 0; RDM = 0; RDW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrc = 0; MemReqM = 0;
    dmem_ack = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_st, exp_fl;

    //              name      rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rsrc pcs mreq ack exp
    tv[0]  = mk("fwd_m_over_w", 0, 0, 5, 0, 0, 5, 5, 1, 1, 2'b00, 0, 0, 0, 12'b10_00_0000_000_0);
    tv[1]  = mk("fwd_w_only",   0, 0, 3, 3, 0, 0, 3, 0, 1, 2'b00, 0, 0, 0, 12'b01_01_0000_000_0);
    tv[2]  = mk("fwd_mixed",    0, 0, 9, 4, 0, 4, 9, 1, 1, 2'b00, 0, 0, 0, 12'b01_10_0000_000_0);
    tv[3]  = mk("fwd_x0",       0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 12'b00_00_0000_000_0);
    tv[4]  = mk("fwd_no_we",    0, 0, 5, 5, 0, 5, 5, 0, 0, 2'b00, 0, 0, 0, 12'b00_00_0000_000_0);
    tv[5]  = mk("lw_rs2",       0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, 0, 0, 12'b00_00_1100_010_0);
    tv[6]  = mk("lw_rs1",       8, 0, 0, 0, 8, 0, 0, 0, 0, 2'b01, 0, 0, 0, 12'b00_00_1100_010_0);
    tv[7]  = mk("lw_rd0",       0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 12'b00_00_0000_000_0);
    tv[8]  = mk("not_load",     7, 0, 0, 0, 7, 0, 0, 0, 0, 2'b10, 0, 0, 0, 12'b00_00_0000_000_0);
    tv[9]  = mk("pcsrc",        0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 12'b00_00_0000_110_0);
    tv[10] = mk("lw_and_pcsrc", 0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b01, 1, 0, 0, 12'b00_00_1100_110_0);
    tv[11] = mk("zero_wait",    0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1, 12'b00_00_0000_000_1);

    // ---- reset: registered outputs clear, combinational path still live
    clear_in();
    rst = 1'b0;
    PCSrc = 1'b1;
    tick(); tick();
    chk("rst_outs", outs, 12'h00C);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    PCSrc = 1'b0;
    rst = 1'b1;
    tick();

    // ---- table of single-cycle vectors; counter model built from expectations
    exp_st = 0; exp_fl = 0;
    for (int i = 0; i < 12; i++) begin
      apply(tv[i]);
      #1;
      chk(tv[i].name, outs, tv[i].exp);
      exp_st += int'(tv[i].exp[7]);
      exp_fl += int'(tv[i].exp[3]);
      tick();
    end
    clear_in();
    #1;
    chk("cnt_stall", stall_cnt, exp_st);
    chk("cnt_flush", flush_cnt, exp_fl);

    // ---- 3 wait cycles then ack: full freeze, released in the ack cycle
    MemReqM = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wait_freeze", outs, 12'h0F3);
      tick();
    end
    dmem_ack = 1'b1;
    #1;
    chk("wait_ack_release", outs, 12'h001);
    tick();
    clear_in();
    #1;
    chk("wait_idle_after", outs, 12'h000);
    tick();

    // ---- redirect + load-use held off during freeze, act once it lifts
    MemReqM = 1'b1; ResultSrcE = 2'b01; RDE = 5'd7; RS2D = 5'd7; PCSrc = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("hold_flush_supp", outs, 12'h0F3);
      tick();
    end
    dmem_ack = 1'b1;
    #1;
    chk("hold_ack_flush", outs, 12'h0CD);
    tick();
    MemReqM = 1'b0; dmem_ack = 1'b0;
    #1;
    chk("hold_after_flush", outs, 12'h0CC);
    tick();
    clear_in();
    tick();

    // ---- timeout: 1 IDLE cycle + 15 WAIT cycles, then sticky ERR
    MemReqM = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("to_freeze", outs, 12'h0F3);
      chk("to_no_err_yet", mem_err, 0);
      tick();
    end
    #1;
    chk("err_outs", outs, 12'h0F2);
    chk("err_flag", mem_err, 1);
    tick();
    MemReqM = 1'b0; dmem_ack = 1'b1;
    #1;
    chk("err_sticky_outs", outs, 12'h0F2);
    chk("err_sticky_flag", mem_err, 1);
    tick();

    // ---- async reset out of ERR takes effect without a clock edge
    dmem_ack = 1'b0;
    rst = 1'b0;
    #1;
    chk("err_rst_flag", mem_err, 0);
    chk("err_rst_outs", outs, 12'h000);
    chk("err_rst_cnt", stall_cnt, 0);
    #1;
    rst = 1'b1;
    tick();

    // ---- first post-reset request serviced normally
    MemReqM = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("post_rst_freeze", outs, 12'h0F3);
      tick();
    end
    dmem_ack = 1'b1;
    #1;
    chk("post_rst_ack", outs, 12'h001);
    chk("post_rst_no_err", mem_err, 0);
    tick();
    clear_in();
    tick();

    // ---- saturation on the 3-bit counters: 10 stall+flush cycles -> 7
    ResultSrcE = 2'b01; RDE = 5'd7; RS1D = 5'd7; PCSrc = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    clear_in();
    #1;
    chk("sat_stall_cnt", d2_scnt, 3'd7);
    chk("sat_flush_cnt", d2_fcnt, 3'd7);
    tick();
    chk("sat_stall_hold", d2_scnt, 3'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
